// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register for a MIPS subset: decodes the ID instruction into ALU
// controls and operands, then registers them under flush/stall/bubble control.
module id_ex_alu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_alu_control,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_is_branch,
    output logic [31:0] ex_store_data,
    output logic        ex_illegal,
    output logic [15:0] issue_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    logic [2:0]  dec_alu;
    logic [31:0] dec_b;
    logic [4:0]  dec_rd;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_is_branch;
    logic        dec_illegal;

    logic        do_clear;
    logic        do_load;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};

    // Unsupported encodings fall through the defaults with only dec_illegal raised.
    always_comb begin
        dec_alu       = ALU_ADD;
        dec_b         = 32'h0;
        dec_rd        = 5'd0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_is_branch = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_b         = rt_data;
                dec_rd        = instr[15:11];
                dec_reg_write = 1'b1;
                case (funct)
                    FN_ADD: dec_alu = ALU_ADD;
                    FN_SUB: dec_alu = ALU_SUB;
                    FN_AND: dec_alu = ALU_AND;
                    FN_OR:  dec_alu = ALU_OR;
                    FN_SLT: dec_alu = ALU_SLT;
                    default: begin
                        dec_b         = 32'h0;
                        dec_rd        = 5'd0;
                        dec_reg_write = 1'b0;
                        dec_illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_b         = imm_sext;
                dec_rd        = instr[20:16];
                dec_reg_write = 1'b1;
            end
            OP_SLTI: begin
                dec_alu       = ALU_SLT;
                dec_b         = imm_sext;
                dec_rd        = instr[20:16];
                dec_reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_alu       = ALU_AND;
                dec_b         = imm_zext;
                dec_rd        = instr[20:16];
                dec_reg_write = 1'b1;
            end
            OP_ORI: begin
                dec_alu       = ALU_OR;
                dec_b         = imm_zext;
                dec_rd        = instr[20:16];
                dec_reg_write = 1'b1;
            end
            OP_LW: begin
                dec_b         = imm_sext;
                dec_rd        = instr[20:16];
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_SW: begin
                dec_b         = imm_sext;
                dec_rd        = instr[20:16];
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu       = ALU_SUB;
                dec_b         = rt_data;
                dec_rd        = instr[20:16];
                dec_is_branch = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Flush wins over stall; an idle unstalled cycle inserts the same empty bubble.
    assign do_clear = flush || (!stall && !in_valid);
    assign do_load  = !flush && !stall && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_a           <= 32'h0;
            ex_b           <= 32'h0;
            ex_alu_control <= 3'b000;
            ex_rd          <= 5'd0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_is_branch   <= 1'b0;
            ex_store_data  <= 32'h0;
            ex_illegal     <= 1'b0;
        end else if (do_clear) begin
            ex_valid       <= 1'b0;
            ex_a           <= 32'h0;
            ex_b           <= 32'h0;
            ex_alu_control <= 3'b000;
            ex_rd          <= 5'd0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_is_branch   <= 1'b0;
            ex_store_data  <= 32'h0;
            ex_illegal     <= 1'b0;
        end else if (do_load) begin
            ex_valid       <= 1'b1;
            ex_a           <= rs_data;
            ex_b           <= dec_b;
            ex_alu_control <= dec_alu;
            ex_rd          <= dec_rd;
            ex_reg_write   <= dec_reg_write;
            ex_mem_read    <= dec_mem_read;
            ex_mem_write   <= dec_mem_write;
            ex_is_branch   <= dec_is_branch;
            ex_store_data  <= rt_data;
            ex_illegal     <= dec_illegal;
        end
    end

    // Counts every accepted instruction, illegal ones included, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= 16'h0;
        end else if (do_load && issue_count != 16'hFFFF) begin
            issue_count <= issue_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares one entry per cycle.
module tb_id_ex_alu_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [2:0]  ex_alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_is_branch;
    logic [31:0] ex_store_data;
    logic        ex_illegal;
    logic [15:0] issue_count;

    typedef struct {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
        logic [31:0] store;
        logic [15:0] cnt;
        logic        chk_ab;
        logic        chk_rd;
        logic        chk_store;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;

    id_ex_alu_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .instr          (instr),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_alu_control (ex_alu_control),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_is_branch   (ex_is_branch),
        .ex_store_data  (ex_store_data),
        .ex_illegal     (ex_illegal),
        .issue_count    (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(ex_valid), 32'h0);
        checkOutput({tag, "_a"}, ex_a, 32'h0);
        checkOutput({tag, "_b"}, ex_b, 32'h0);
        checkOutput({tag, "_alu"}, 32'(ex_alu_control), 32'h0);
        checkOutput({tag, "_rd"}, 32'(ex_rd), 32'h0);
        checkOutput({tag, "_flags"}, {28'h0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}, 32'h0);
        checkOutput({tag, "_store"}, ex_store_data, 32'h0);
        checkOutput({tag, "_illegal"}, 32'(ex_illegal), 32'h0);
        checkOutput({tag, "_count"}, 32'(issue_count), 32'h0);
    endtask

    function automatic exp_t expLoad(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                                     input logic br, input logic ill, input logic [31:0] store,
                                     input logic [15:0] cnt);
        exp_t e;
        e.valid     = 1'b1;
        e.a         = a;
        e.b         = b;
        e.alu       = alu;
        e.rd        = rd;
        e.rw        = rw;
        e.mr        = mr;
        e.mw        = mw;
        e.br        = br;
        e.ill       = ill;
        e.store     = store;
        e.cnt       = cnt;
        e.chk_ab    = !ill;
        e.chk_rd    = rw;
        e.chk_store = mw;
        return e;
    endfunction

    function automatic exp_t expEmpty(input logic [15:0] cnt);
        exp_t e;
        e           = expLoad(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, cnt);
        e.valid     = 1'b0;
        e.chk_rd    = 1'b1;
        e.chk_store = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic st, input logic fl, input exp_t e);
        @(negedge clk);
        #1;
        in_valid = v;
        instr    = ins;
        rs_data  = rs;
        rt_data  = rt;
        stall    = st;
        flush    = fl;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry describes the EX register contents after each edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("sb_valid", 32'(ex_valid), 32'(e.valid));
            checkOutput("sb_alu", 32'(ex_alu_control), 32'(e.alu));
            checkOutput("sb_flags", {28'h0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch},
                        {28'h0, e.rw, e.mr, e.mw, e.br});
            checkOutput("sb_illegal", 32'(ex_illegal), 32'(e.ill));
            checkOutput("sb_count", 32'(issue_count), 32'(e.cnt));
            if (e.chk_ab) begin
                checkOutput("sb_a", ex_a, e.a);
                checkOutput("sb_b", ex_b, e.b);
            end
            if (e.chk_rd)
                checkOutput("sb_rd", 32'(ex_rd), 32'(e.rd));
            if (e.chk_store)
                checkOutput("sb_store", ex_store_data, e.store);
        end
    end

    exp_t sw_exp;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = 32'h0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        stall    = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // R-type group
        applyStimulus(1, 32'h014B4820, 32'd5, 32'd7, 0, 0,
                      expLoad(3'b000, 32'd5, 32'd7, 5'd9, 1, 0, 0, 0, 0, 32'd7, 16'd1));
        applyStimulus(1, 32'h00221822, 32'd20, 32'd3, 0, 0,
                      expLoad(3'b001, 32'd20, 32'd3, 5'd3, 1, 0, 0, 0, 0, 32'd3, 16'd2));
        applyStimulus(1, 32'h00221824, 32'hF0F0, 32'h0FF0, 0, 0,
                      expLoad(3'b010, 32'hF0F0, 32'h0FF0, 5'd3, 1, 0, 0, 0, 0, 32'h0FF0, 16'd3));
        applyStimulus(1, 32'h00221825, 32'h1, 32'h2, 0, 0,
                      expLoad(3'b011, 32'h1, 32'h2, 5'd3, 1, 0, 0, 0, 0, 32'h2, 16'd4));
        applyStimulus(1, 32'h0022182A, 32'h9, 32'hA, 0, 0,
                      expLoad(3'b100, 32'h9, 32'hA, 5'd3, 1, 0, 0, 0, 0, 32'hA, 16'd5));

        // I-type immediates: sign vs zero extension
        applyStimulus(1, 32'h2128FFFF, 32'h100, 32'h55, 0, 0,
                      expLoad(3'b000, 32'h100, 32'hFFFFFFFF, 5'd8, 1, 0, 0, 0, 0, 32'h55, 16'd6));
        applyStimulus(1, 32'h3528FFFF, 32'h100, 32'h55, 0, 0,
                      expLoad(3'b011, 32'h100, 32'h0000FFFF, 5'd8, 1, 0, 0, 0, 0, 32'h55, 16'd7));
        applyStimulus(1, 32'h2928FFF0, 32'h7, 32'h0, 0, 0,
                      expLoad(3'b100, 32'h7, 32'hFFFFFFF0, 5'd8, 1, 0, 0, 0, 0, 32'h0, 16'd8));
        applyStimulus(1, 32'h31288000, 32'h3, 32'h0, 0, 0,
                      expLoad(3'b010, 32'h3, 32'h00008000, 5'd8, 1, 0, 0, 0, 0, 32'h0, 16'd9));
        applyStimulus(1, 32'h8D280004, 32'h2000, 32'h0, 0, 0,
                      expLoad(3'b000, 32'h2000, 32'h4, 5'd8, 1, 1, 0, 0, 0, 32'h0, 16'd10));
        applyStimulus(1, 32'h11280010, 32'h44, 32'h45, 0, 0,
                      expLoad(3'b001, 32'h44, 32'h45, 5'd8, 0, 0, 0, 1, 0, 32'h45, 16'd11));

        // Illegal encodings still count as issued
        applyStimulus(1, 32'h00221827, 32'h1, 32'h2, 0, 0,
                      expLoad(3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h0, 16'd12));
        applyStimulus(1, 32'hFC000000, 32'h1, 32'h2, 0, 0,
                      expLoad(3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h0, 16'd13));

        applyStimulus(0, 32'h014B4820, 32'h1, 32'h2, 0, 0, expEmpty(16'd13));

        // Store held through a 3-cycle stall with a different instruction presented
        sw_exp = expLoad(3'b000, 32'h1000, 32'h4, 5'd10, 0, 0, 1, 0, 0, 32'hCAFE, 16'd14);
        applyStimulus(1, 32'hAD2A0004, 32'h1000, 32'hCAFE, 0, 0, sw_exp);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 32'h014B4820, 32'h77, 32'h88, 1, 0, sw_exp);
        applyStimulus(1, 32'h014B4820, 32'h77, 32'h88, 1, 1, expEmpty(16'd14));
        applyStimulus(1, 32'h014B4820, 32'h5, 32'h7, 0, 0,
                      expLoad(3'b000, 32'd5, 32'd7, 5'd9, 1, 0, 0, 0, 0, 32'd7, 16'd15));
        applyStimulus(1, 32'h014B4820, 32'h5, 32'h7, 0, 1, expEmpty(16'd15));
        applyStimulus(1, 32'h014B4820, 32'h5, 32'h7, 0, 0,
                      expLoad(3'b000, 32'd5, 32'd7, 5'd9, 1, 0, 0, 0, 0, 32'd7, 16'd16));

        // Asynchronous reset between edges, with stall and flush both asserted
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);
        checkOutput("pre_reset_valid", 32'(ex_valid), 32'h1);
        stall = 1'b1;
        flush = 1'b1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("post_reset_stall");
        mon_en = 1'b1;
        applyStimulus(1, 32'h014B4820, 32'h5, 32'h7, 0, 0,
                      expLoad(3'b000, 32'd5, 32'd7, 5'd9, 1, 0, 0, 0, 0, 32'd7, 16'd1));

        // Saturation: 65536 accepted instructions after a fresh reset
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        instr    = 32'h2128FFFF;
        stall    = 1'b0;
        flush    = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("count_fffe", 32'(issue_count), 32'h0000FFFE);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("count_ffff", 32'(issue_count), 32'h0000FFFF);
        @(posedge clk);
        #1;
        checkOutput("count_saturated", 32'(issue_count), 32'h0000FFFF);
        checkOutput("sat_valid", 32'(ex_valid), 32'h1);

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
